mul_op_sequencer: RTL and testbench

Operand front-end for the 32-bit unsigned shift-add multiplier. Accepts operand pairs on a valid/ready input, buffers them in a small FIFO, issues each pair to the multiplier with a one-cycle start pulse, and holds M/Q stable for the whole operation. On the multiplier's done pulse it captures the 64-bit product into a valid/ready output register, together with the operand's tag. A watchdog flags operations that never complete.

---
 rtl/mul_op_sequencer.sv | 202 ++++++++++++++++++++
 tb/tb_mul_op_sequencer.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_op_sequencer.sv
// mul_op_sequencer
//
// Operand front-end for the 32-bit unsigned shift-add multiplier.
// Operand pairs come in on a valid/ready port and are buffered in a small
// FIFO. Each pair is issued to the multiplier with a one-cycle start pulse.
// M and Q are held stable until the multiplier reports done or the watchdog
// gives up. The product and the operation's tag are then captured into a
// valid/ready result register. Only one operation is in flight at a time.
//
// Ports:
//   clk, n_rst             clock; asynchronous active-low reset
//   in_valid/in_ready      operand handshake (in_ready = FIFO not full)
//   in_m, in_q, in_tag     multiplicand, multiplier, user tag
//   mul_start              one-cycle start pulse to the multiplier
//   mul_m, mul_q           registered operands held for the whole operation
//   mul_done, mul_result   completion pulse and product from the multiplier
//   out_valid/out_ready    result handshake
//   out_result, out_tag    product (0 on timeout) and its tag
//   out_err                result was abandoned by the watchdog
//   busy                   FIFO non-empty, FSM active, or result pending
//
// States:
//   state | meaning
//   IDLE  | waiting for a queued operand and a free result slot
//   START | operands loaded, mul_start asserted for this cycle only
//   WAIT  | multiplier running; watchdog counting

module mul_op_sequencer #(
    parameter int DEPTH   = 4,
    parameter int TAG_W   = 4,
    parameter int TIMEOUT = 40
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_m,
    input  logic [31:0]      in_q,
    input  logic [TAG_W-1:0] in_tag,
    output logic             mul_start,
    output logic [31:0]      mul_m,
    output logic [31:0]      mul_q,
    input  logic             mul_done,
    input  logic [63:0]      mul_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_result,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_err,
    output logic             busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int WD_W  = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2
    } state_t;

    typedef struct packed {
        logic [31:0]      m;
        logic [31:0]      q;
        logic [TAG_W-1:0] tag;
    } entry_t;

    state_t state, state_n;

    entry_t             fifo_mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic               full;
    logic               empty;
    logic               push;
    logic               pop;

    logic [WD_W-1:0]    wd_cnt;
    logic [TAG_W-1:0]   tag_r;
    logic               cap_done;
    logic               cap_timeout;

    // ---------------- operand FIFO ----------------
    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign in_ready = !full;
    assign push     = in_valid && in_ready;

    // Storage needs no reset: an entry is only read after it has been written.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= '{m: in_m, q: in_q, tag: in_tag};
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= IDLE;
        else        state <= state_n;
    end

    always_comb begin
        state_n     = state;
        mul_start   = 1'b0;
        pop         = 1'b0;
        cap_done    = 1'b0;
        cap_timeout = 1'b0;
        case (state)
            IDLE: begin
                // Issue only when the result slot is free or being drained
                // this edge, so a capture never overwrites an unread result.
                if (!empty && (!out_valid || out_ready)) begin
                    pop     = 1'b1;
                    state_n = START;
                end
            end
            START: begin
                mul_start = 1'b1;
                state_n   = WAIT;
            end
            WAIT: begin
                if (mul_done) begin
                    cap_done = 1'b1;
                    state_n  = IDLE;
                end else if (wd_cnt == WD_W'(TIMEOUT - 1)) begin
                    cap_timeout = 1'b1;
                    state_n     = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wd_cnt <= '0;
        end else if (state == START) begin
            wd_cnt <= '0;
        end else if (state == WAIT) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    // ---------------- operand hold registers ----------------
    // The multiplier reads M combinationally every iteration, so these only
    // change on the issue edge.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mul_m <= '0;
            mul_q <= '0;
            tag_r <= '0;
        end else if (pop) begin
            mul_m <= fifo_mem[rd_ptr].m;
            mul_q <= fifo_mem[rd_ptr].q;
            tag_r <= fifo_mem[rd_ptr].tag;
        end
    end

    // ---------------- result register ----------------
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            out_valid  <= 1'b0;
            out_result <= '0;
            out_tag    <= '0;
            out_err    <= 1'b0;
        end else if (cap_done) begin
            out_valid  <= 1'b1;
            out_result <= mul_result;
            out_tag    <= tag_r;
            out_err    <= 1'b0;
        end else if (cap_timeout) begin
            out_valid  <= 1'b1;
            out_result <= '0;
            out_tag    <= tag_r;
            out_err    <= 1'b1;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    assign busy = !empty || (state != IDLE) || out_valid;

endmodule

// File: tb/tb_mul_op_sequencer.sv
module tb_mul_op_sequencer;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_m;
    logic [31:0] in_q;
    logic [3:0]  in_tag;
    logic        mul_start;
    logic [31:0] mul_m;
    logic [31:0] mul_q;
    logic        mul_done;
    logic [63:0] mul_result;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_result;
    logic [3:0]  out_tag;
    logic        out_err;
    logic        busy;

    logic        tb_done;
    logic        mdl_done;
    logic        stall;
    logic        mdl_active;
    int          mdl_cnt;

    int checks = 0;
    int errors = 0;

    assign mul_done = mdl_done | tb_done;

    always #5 clk = ~clk;

    mul_op_sequencer #(.DEPTH(4), .TAG_W(4), .TIMEOUT(40)) dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_m       (in_m),
        .in_q       (in_q),
        .in_tag     (in_tag),
        .mul_start  (mul_start),
        .mul_m      (mul_m),
        .mul_q      (mul_q),
        .mul_done   (mul_done),
        .mul_result (mul_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_tag    (out_tag),
        .out_err    (out_err),
        .busy       (busy)
    );

    // Nominal multiplier: done high during the cycle after start-edge + 33.
    // With stall set it never finishes.
    always @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            mdl_active <= 1'b0;
            mdl_cnt    <= 0;
            mdl_done   <= 1'b0;
            mul_result <= '0;
        end else begin
            mdl_done <= 1'b0;
            if (mul_start && !stall) begin
                mdl_active <= 1'b1;
                mdl_cnt    <= 33;
                mul_result <= {32'd0, mul_m} * {32'd0, mul_q};
            end else if (mdl_active) begin
                if (mdl_cnt == 1) begin
                    mdl_done   <= 1'b1;
                    mdl_active <= 1'b0;
                end
                mdl_cnt <= mdl_cnt - 1;
            end
        end
    end

    task automatic push(input logic [31:0] m, input logic [31:0] q, input logic [3:0] tag);
        @(negedge clk);
        in_valid = 1'b1; in_m = m; in_q = q; in_tag = tag;
        for (int i = 0; i < 300 && !in_ready; i++) @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_wait tag=%0d: in_ready=%b required 1", tag, in_ready);
        end
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic try_push(input logic [31:0] m, input logic [31:0] q, input logic [3:0] tag,
                            output logic acc);
        @(negedge clk);
        in_valid = 1'b1; in_m = m; in_q = q; in_tag = tag;
        acc = in_ready;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int k);
        k = 0;
        while (!out_valid && k < bound) begin
            @(negedge clk);
            k++;
        end
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic apply_reset();
        n_rst = 1'b0; in_valid = 1'b0; in_m = '0; in_q = '0; in_tag = '0;
        out_ready = 1'b0; tb_done = 1'b0; stall = 1'b0;
        repeat (3) @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
    endtask

    task automatic check_reset_values(input string name);
        checks++;
        if ({in_ready, mul_start, out_valid, out_err, busy} !== 5'b10000) begin
            errors++;
            $display("FAIL %s flags: in_ready/mul_start/out_valid/out_err/busy=%b required 10000",
                     name, {in_ready, mul_start, out_valid, out_err, busy});
        end
        checks++;
        if (mul_m !== 32'd0 || mul_q !== 32'd0) begin
            errors++;
            $display("FAIL %s operands: mul_m=%h mul_q=%h required 0", name, mul_m, mul_q);
        end
        checks++;
        if (out_result !== 64'd0 || out_tag !== 4'd0) begin
            errors++;
            $display("FAIL %s result: out_result=%h out_tag=%h required 0", name, out_result, out_tag);
        end
    endtask

    task automatic test_reset();
        apply_reset();
        check_reset_values("reset");
    endtask

    task automatic test_single();
        int k;
        int starts;
        out_ready = 1'b0;
        push(32'd3, 32'd5, 4'd1);
        k = 0; starts = 0;
        while (!out_valid && k < 100) begin
            @(negedge clk);
            k++;
            if (mul_start) starts++;
        end
        checks++;
        if (k != 36) begin errors++; $display("FAIL single_latency: got %0d required 36", k); end
        checks++;
        if (starts != 1) begin errors++; $display("FAIL single_starts: got %0d required 1", starts); end
        checks++;
        if (out_result !== 64'h0000_0000_0000_000F) begin
            errors++; $display("FAIL single_result: got %h required 000000000000000f", out_result);
        end
        checks++;
        if (out_tag !== 4'd1 || out_err !== 1'b0) begin
            errors++; $display("FAIL single_tag_err: tag=%0d err=%b required 1/0", out_tag, out_err);
        end
        consume();
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL single_drain: out_valid=%b busy=%b required 0/0", out_valid, busy);
        end
    endtask

    task automatic test_max_operands();
        int k;
        out_ready = 1'b0;
        push(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd2);
        k = 0;
        while (!mul_start && k < 10) begin @(negedge clk); k++; end
        while (!out_valid && k < 100) begin
            checks++;
            if (mul_m !== 32'hFFFF_FFFF || mul_q !== 32'hFFFF_FFFF) begin
                errors++;
                $display("FAIL max_hold cycle %0d: mul_m=%h mul_q=%h required ffffffff", k, mul_m, mul_q);
            end
            @(negedge clk);
            k++;
        end
        checks++;
        if (out_result !== 64'hFFFF_FFFE_0000_0001 || out_tag !== 4'd2) begin
            errors++;
            $display("FAIL max_result: got %h tag %0d required fffffffe00000001 tag 2", out_result, out_tag);
        end
        consume();
    endtask

    task automatic test_backpressure();
        logic [31:0] bm [6];
        logic [31:0] bq [6];
        logic [63:0] bp [6];
        logic acc;
        int k;
        bm = '{32'd2, 32'd3, 32'h0001_0000, 32'd7, 32'hFFFF_FFFF, 32'd100};
        bq = '{32'd3, 32'd4, 32'h0001_0000, 32'd0, 32'd2, 32'd5};
        bp = '{64'd6, 64'd12, 64'h1_0000_0000, 64'd0, 64'h1_FFFF_FFFE, 64'd500};
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            try_push(bm[i], bq[i], 4'(i + 1), acc);
            checks++;
            if (acc !== 1'b1) begin errors++; $display("FAIL bp_accept op%0d: accepted=%b required 1", i + 1, acc); end
        end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_full: in_ready=%b required 0", in_ready); end
        try_push(bm[5], bq[5], 4'd6, acc);
        checks++;
        if (acc !== 1'b0) begin errors++; $display("FAIL bp_reject op6: accepted=%b required 0", acc); end
        wait_valid(100, k);
        checks++;
        if (out_valid !== 1'b1 || out_tag !== 4'd1) begin
            errors++; $display("FAIL bp_first: out_valid=%b tag=%0d required 1/1", out_valid, out_tag);
        end
        repeat (5) @(negedge clk);
        checks++;
        if (in_ready !== 1'b0 || mul_start !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL bp_hold: in_ready=%b mul_start=%b busy=%b required 0/0/1", in_ready, mul_start, busy);
        end
        out_ready = 1'b1;
        fork
            push(bm[5], bq[5], 4'd6);
            begin
                int idx;
                int last;
                int t;
                idx = 0; last = 0; t = 0;
                while (idx < 6 && t < 600) begin
                    if (out_valid) begin
                        checks++;
                        if (out_tag !== 4'(idx + 1) || out_result !== bp[idx] || out_err !== 1'b0) begin
                            errors++;
                            $display("FAIL bp_order idx %0d: tag=%0d result=%h err=%b required tag %0d result %h err 0",
                                     idx, out_tag, out_result, out_err, idx + 1, bp[idx]);
                        end
                        if (idx > 0) begin
                            checks++;
                            if (t - last != 36) begin
                                errors++;
                                $display("FAIL bp_spacing idx %0d: got %0d required 36", idx, t - last);
                            end
                        end
                        idx++;
                        last = t;
                    end
                    @(negedge clk);
                    t++;
                end
                checks++;
                if (idx != 6) begin errors++; $display("FAIL bp_count: got %0d results required 6", idx); end
            end
        join
        out_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_watchdog();
        int k;
        out_ready = 1'b0;
        stall = 1'b1;
        push(32'd5, 32'd5, 4'd7);
        wait_valid(100, k);
        checks++;
        if (k != 42) begin errors++; $display("FAIL wd_latency: got %0d required 42", k); end
        checks++;
        if (out_err !== 1'b1 || out_result !== 64'd0 || out_tag !== 4'd7) begin
            errors++;
            $display("FAIL wd_result: err=%b result=%h tag=%0d required 1/0/7", out_err, out_result, out_tag);
        end
        stall = 1'b0;
        push(32'd6, 32'd7, 4'd8);
        consume();
        wait_valid(100, k);
        checks++;
        if (out_valid !== 1'b1 || out_result !== 64'd42 || out_tag !== 4'd8 || out_err !== 1'b0) begin
            errors++;
            $display("FAIL wd_next: valid=%b result=%h tag=%0d err=%b required 1/2a/8/0",
                     out_valid, out_result, out_tag, out_err);
        end
        consume();
    endtask

    task automatic test_reset_mid_wait();
        int k;
        out_ready = 1'b0;
        push(32'd11, 32'd13, 4'd3);
        k = 0;
        while (!mul_start && k < 10) begin @(negedge clk); k++; end
        push(32'd2, 32'd2, 4'd4);
        repeat (8) @(negedge clk);
        n_rst = 1'b0;
        #1;
        check_reset_values("reset_mid");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (50) @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_flush: out_valid=%b busy=%b required 0/0", out_valid, busy);
        end
        push(32'd7, 32'd9, 4'd5);
        wait_valid(100, k);
        checks++;
        if (k != 36 || out_result !== 64'd63 || out_tag !== 4'd5) begin
            errors++;
            $display("FAIL reset_fresh: latency=%0d result=%h tag=%0d required 36/3f/5", k, out_result, out_tag);
        end
        consume();
    endtask

    task automatic test_stray_done();
        int k;
        out_ready = 1'b0;
        @(negedge clk);
        tb_done = 1'b1;
        @(negedge clk);
        tb_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (out_valid !== 1'b0 || busy !== 1'b0 || mul_start !== 1'b0) begin
                errors++;
                $display("FAIL stray_done cycle %0d: out_valid=%b busy=%b mul_start=%b required 0/0/0",
                         i, out_valid, busy, mul_start);
            end
        end
        push(32'd4, 32'd4, 4'd6);
        wait_valid(100, k);
        checks++;
        if (k != 36 || out_result !== 64'd16 || out_tag !== 4'd6) begin
            errors++;
            $display("FAIL stray_after: latency=%0d result=%h tag=%0d required 36/10/6", k, out_result, out_tag);
        end
        consume();
    endtask

    initial begin
        test_reset();
        test_single();
        test_max_operands();
        test_backpressure();
        test_watchdog();
        test_reset_mid_wait();
        test_stray_done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
